// File: rtl/decode_pkg.sv
// Shared decode definitions: RV32I opcode constants, the immediate format
// type, and the entry record carried through the decode skid buffer.
package decode_pkg;

  `include "immediate.svh"

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // Storage width of the PC field; a stage's PC_WIDTH must not exceed it.
  localparam int unsigned PC_WIDTH_MAX = 32;

  typedef struct packed {
    logic [31:0]             instruction;
    logic [PC_WIDTH_MAX-1:0] pc;
    logic [31:0]             immediate;
    immediate_e              imm_type;
    logic                    illegal;
  } decode_entry_t;

endpackage

// File: rtl/immediate.svh
// Immediate format selector shared by the decode stage and its immediate
// generator. Included from decode_pkg so that every importer sees one type.
`ifndef IMMEDIATE_SVH
`define IMMEDIATE_SVH

typedef enum logic [2:0] {
  IMM_I = 3'd0,
  IMM_S = 3'd1,
  IMM_B = 3'd2,
  IMM_U = 3'd3,
  IMM_J = 3'd4
} immediate_e;

`endif

// File: rtl/immediate_generator.sv
// Builds the sign-extended 32-bit RV32I immediate for a given format.
// Ports:
//   instr_payload  in  25           instruction bits [31:7] (opcode not needed)
//   imm_type       in  immediate_e  format to extract
//   immediate      out 32           sign-extended immediate
module immediate_generator
  import decode_pkg::*;
(
  input  logic [24:0] instr_payload,
  input  immediate_e  imm_type,
  output logic [31:0] immediate
);

  // Payload index = instruction bit - 7.
  logic [24:0] p;
  assign p = instr_payload;

  always_comb begin
    // NOTE: the I-format default is assigned before the case so every path
    // drives the output; a missing assignment would infer a latch.
    immediate = {{20{p[24]}}, p[24:13]};
    case (imm_type)
      IMM_S:   immediate = {{20{p[24]}}, p[24:18], p[4:0]};
      IMM_B:   immediate = {{19{p[24]}}, p[24], p[0], p[23:18], p[4:1], 1'b0};
      IMM_U:   immediate = {p[24:5], 12'b0};
      IMM_J:   immediate = {{11{p[24]}}, p[24], p[12:5], p[13], p[23:14], 1'b0};
      default: ;
    endcase
  end

endmodule

// File: rtl/decode_immediate_stage.sv
// Decode-stage front end: classifies each fetched instruction by opcode,
// generates its immediate and holds results in a 2-entry skid buffer
// (main entry drives out_*, skid entry absorbs one accept under stall).
// Ports:
//   clk_i, rst_ni            clock, async active-low reset
//   flush_i                  drop all buffered entries and same-cycle input
//   in_valid_i / in_ready_o  fetch handshake (in_ready_o registered)
//   in_instruction_i/in_pc_i instruction word and its PC
//   out_valid_o/out_ready_i  downstream handshake
//   out_*                    head entry: instruction, pc, immediate, format, illegal
//   stall_count_o            saturating count of back-pressured cycles
module decode_immediate_stage
  import decode_pkg::*;
#(
  parameter int unsigned PC_WIDTH    = 32,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [31:0]            in_instruction_i,
  input  logic [PC_WIDTH-1:0]    in_pc_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [31:0]            out_instruction_o,
  output logic [PC_WIDTH-1:0]    out_pc_o,
  output logic [31:0]            out_immediate_o,
  output immediate_e             out_imm_type_o,
  output logic                   out_illegal_o,
  output logic [STALL_CNT_W-1:0] stall_count_o
);

  immediate_e    dec_type;
  logic          dec_illegal;
  logic [31:0]   dec_imm;
  decode_entry_t new_entry;

  // Any opcode outside the map (including compressed encodings, whose low
  // bits are not 2'b11) falls to the default and is flagged illegal.
  always_comb begin
    dec_type    = IMM_I;
    dec_illegal = 1'b0;
    case (in_instruction_i[6:0])
      OPC_LUI, OPC_AUIPC: dec_type = IMM_U;
      OPC_JAL:            dec_type = IMM_J;
      OPC_BRANCH:         dec_type = IMM_B;
      OPC_STORE:          dec_type = IMM_S;
      OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_OP, OPC_MISC_MEM, OPC_SYSTEM:
                          dec_type = IMM_I;
      default:            dec_illegal = 1'b1;
    endcase
  end

  immediate_generator u_imm_gen (
    .instr_payload (in_instruction_i[31:7]),
    .imm_type      (dec_type),
    .immediate     (dec_imm)
  );

  assign new_entry = '{instruction: in_instruction_i,
                       pc:          PC_WIDTH_MAX'(in_pc_i),
                       immediate:   dec_imm,
                       imm_type:    dec_type,
                       illegal:     dec_illegal};

  decode_entry_t          main_q, main_d, skid_q, skid_d;
  logic                   main_valid_q, main_valid_d;
  logic                   skid_valid_q, skid_valid_d;
  logic                   in_ready_q;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;
  logic                   accept, pop;

  assign accept = in_valid_i & in_ready_q & ~flush_i;
  assign pop    = main_valid_q & out_ready_i;

  // in_ready_q mirrors !skid_valid_q, so an accept never coincides with a
  // full skid entry; a pop with skid valid therefore never needs a refill.
  always_comb begin
    // NOTE: combinational next-state uses blocking assignments; the
    // registers below take these values with non-blocking assignments.
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush_i) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (pop) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = accept;
        if (accept) main_d = new_entry;
      end
    end else if (accept) begin
      if (main_valid_q) begin
        skid_d       = new_entry;
        skid_valid_d = 1'b1;
      end else begin
        main_d       = new_entry;
        main_valid_d = 1'b1;
      end
    end
  end

  // Flush deliberately leaves the stall counter alone.
  always_comb begin
    stall_d = stall_q;
    if (main_valid_q && !out_ready_i && !(&stall_q))
      stall_d = stall_q + STALL_CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: entry payloads are reset too, because the data outputs must
      // read zero out of reset rather than whatever the flops power up with.
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      stall_q      <= '0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= ~skid_valid_d;
      stall_q      <= stall_d;
    end
  end

  assign in_ready_o        = in_ready_q;
  assign out_valid_o       = main_valid_q;
  assign out_instruction_o = main_q.instruction;
  assign out_pc_o          = main_q.pc[PC_WIDTH-1:0];
  assign out_immediate_o   = main_q.immediate;
  assign out_imm_type_o    = main_q.imm_type;
  assign out_illegal_o     = main_q.illegal;
  assign stall_count_o     = stall_q;

endmodule
